// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_issue_ctrl_if : command/result handshake bundle for alu_issue_ctrl   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_sel;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_chain;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_chain, res_ready,
    input  cmd_ready, res_valid, res_data, res_carry
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_chain, res_ready,
    output cmd_ready, res_valid, res_data, res_carry
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_issue_ctrl : registered issue/capture front-end for the 8-bit ALU    |
// | Revision 1.0   | optional carry-sticky flag: ALU_ISSUE_STICKY_EN          |
// +--------------------------------------------------------------------------+
module alu_issue_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_issue_ctrl_if.slave      bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_sel,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_carry,
  output logic [CNT_WIDTH-1:0] op_count
`ifdef ALU_ISSUE_STICKY_EN
  ,
  input  logic                 sticky_clr,
  output logic                 carry_sticky
`endif
);

  localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic                 r_cmd_ready;
  logic                 r_res_valid;
  logic [WIDTH-1:0]     r_res_data;
  logic                 r_res_carry;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_alu_a;
  logic [WIDTH-1:0]     r_alu_b;
  logic [3:0]           r_alu_sel;
  logic [CNT_WIDTH-1:0] r_op_count;
  logic                 w_capture;

  assign w_capture = (r_state == DRIVE) && (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_cmd_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_acc       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= 4'd0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid && r_cmd_ready) begin
            r_alu_sel   <= bus.cmd_sel;
            r_alu_b     <= bus.cmd_b;
            r_alu_a     <= bus.cmd_chain ? r_acc : bus.cmd_a;
            r_cnt       <= c_SETTLE_LOAD;
            r_cmd_ready <= 1'b0;
            r_state     <= DRIVE;
          end
        end
        DRIVE: begin
          if (w_capture) begin
            r_res_data  <= alu_out;
            r_res_carry <= alu_carry;
            r_acc       <= alu_out;
            r_res_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_op_count  <= r_op_count + 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_STICKY_EN
  logic r_carry_sticky;

  // A carry capture outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry_sticky <= 1'b0;
    end else if (w_capture && alu_carry) begin
      r_carry_sticky <= 1'b1;
    end else if (sticky_clr) begin
      r_carry_sticky <= 1'b0;
    end
  end

  assign carry_sticky = r_carry_sticky;
`endif

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_carry = r_res_carry;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_sel       = r_alu_sel;
  assign op_count      = r_op_count;

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential front-end for the 8-bit combinational ALU.
- Accepts operation commands over a valid/ready handshake and drives registered operands and opcode into the ALU (A, B, ALU_Sel).
- Waits a programmable settle time, then captures ALU_Out/CarryOut into a result register and accumulator.
- Returns the result over a second valid/ready handshake.
- Sits directly upstream of the ALU and also consumes its outputs; this gives the ALU its only clocked boundary.

Parameters:
WIDTH, 8, operand/result width; must match the ALU.
SETTLE_CYCLES, 1, cycles operands are held before capture; legal range 1..15; 0 is illegal.
CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_sel  in  4  ALU opcode
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
cmd_chain  in  1  1: use accumulator as A; cmd_a ignored
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_sel  out  4  to ALU ALU_Sel
alu_out  in  WIDTH  from ALU ALU_Out
alu_carry  in  1  from ALU CarryOut
res_valid  out  1  result present
res_ready  in  1  consumer accepts result
res_data  out  WIDTH  captured ALU_Out
res_carry  out  1  captured CarryOut
op_count  out  CNT_WIDTH  completed (handshaken) results, wraps

Behaviour:
- Reset (rst=1 at edge): state=IDLE; cmd_ready=1 from the following cycle; res_valid=0; alu_a/alu_b/alu_sel=0; res_data=0; res_carry=0; accumulator=0; op_count=0; settle counter=0.
- Reset mid-operation aborts the operation; the in-flight result is discarded and never presented.
- FSM states: IDLE, DRIVE, RESP. All outputs are registered.
- IDLE: cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch alu_sel<=cmd_sel, alu_b<=cmd_b, alu_a<=(cmd_chain ? accumulator : cmd_a).
  - Load settle counter with SETTLE_CYCLES-1; go to DRIVE.
- DRIVE: cmd_ready=0; alu_a/alu_b/alu_sel held stable.
  - Counter nonzero: decrement.
  - Counter zero: res_data<=alu_out, res_carry<=alu_carry, accumulator<=alu_out; res_valid<=1; go to RESP.
- RESP: res_valid=1; res_data and res_carry held stable.
  - On res_ready: res_valid<=0, op_count<=op_count+1 (wraps to 0 at all-ones), go to IDLE.
- Latency: command accepted at edge N, res_valid high after edge N+SETTLE_CYCLES. The next command is accepted no earlier than the edge after the result handshake. Max throughput is 1 op per SETTLE_CYCLES+2 cycles.
- alu_a/alu_b/alu_sel keep their last values in IDLE and RESP; they are not zeroed.
- cmd_valid while cmd_ready=0: ignored and not queued; the producer must hold it.
- res_ready while res_valid=0: no effect.
- cmd_chain after reset uses accumulator=0.
- Chain uses the most recently captured result, whether or not it has been handshaken yet.
- No arithmetic is performed in this block; widths pass through unchanged.

Optional Feature:
Macro ALU_ISSUE_STICKY_EN.
- Defined:
  - Adds input sticky_clr (1 bit) and output carry_sticky (1 bit, reset 0).
  - carry_sticky is set on any DRIVE capture with alu_carry=1 and cleared by sticky_clr=1.
  - If capture with carry and sticky_clr occur in the same cycle, set wins.
- Undefined: neither port exists and no sticky logic is synthesised.

Test Plan:
- Bench ALU model: sel 4'b0000 = add, A+B with carry = bit 8.
- Reset: hold rst 3 cycles with cmd_valid=1 -> all outputs 0, cmd_ready=1 after release, no result produced.
- Basic add: sel=0, A=8'h12, B=8'h34, SETTLE_CYCLES=1, res_ready=1 -> res_valid exactly 1 cycle after accept, res_data=8'h46, res_carry=0, op_count=1.
- Carry and chain:
  - Step 1: A=8'hF0, B=8'h20 -> res_data=8'h10, res_carry=1.
  - Step 2: cmd_chain=1, cmd_a=8'hFF, B=8'h05 -> alu_a=8'h10, res_data=8'h15, res_carry=0.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_data stable, cmd_ready=0, extra cmd_valid ignored; res_ready=1 -> op_count increments once.
- Settle and reset: SETTLE_CYCLES=4 -> res_valid exactly 4 cycles after accept; rst asserted in DRIVE -> res_valid never rises, op_count unchanged at 0.
- Sticky (ALU_ISSUE_STICKY_EN): carry op (F0+20) -> carry_sticky=1 held through a no-carry op; sticky_clr=1 coinciding with a carry capture -> stays 1; sticky_clr alone -> 0.
